// File: rtl/sha256_pkg.sv
// Shared SHA-256 types: job context record plus scheduler state and limits.
package sha256_pkg;

  typedef struct packed {
    logic [63:0] length;
    logic [31:0] msg_addr;
    logic [31:0] dig_addr;
    logic [7:0]  job_id;
  } ShaContext;

  typedef enum logic {SCHED_IDLE, SCHED_OFFER} SchedState;

  localparam int SCHED_MAX_CORES = 8;

endpackage

// File: rtl/sha256_job_fifo.sv
// Synchronous job FIFO of ShaContext records. Push is ignored while full and
// pop is ignored while empty. head shows the oldest entry whenever the FIFO is
// non-empty. count_nxt is the occupancy that the next edge will produce.
module sha256_job_fifo
  import sha256_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  ShaContext     push_ctx,
  input  logic          pop,
  output ShaContext     head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count_nxt
);

  ShaContext       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
  assign count_nxt = cnt_d;

  // Gate the requests and advance the pointers; pointers wrap at DEPTH.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_ctx;
    end
  end

endmodule

// File: rtl/sha256_sched.sv
// Round-robin job scheduler in front of a bank of sha256 cores.
// Jobs are buffered in sha256_job_fifo and offered to one ready core at a
// time over its ctx_vld/ctx_rdy handshake. An offer is never retracted.
// Optional macro SHA256_SCHED_STATS_EN adds accept/dispatch counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SCHED_IDLE  | waiting for a buffered job and at least one ready core
// SCHED_OFFER | core_ctx_vld[sel] held with a stable core_ctx until taken
module sha256_sched
  import sha256_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int JOB_DEPTH = 4,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int FAW       = $clog2(JOB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_vld,
  output logic                  job_rdy,
  input  ShaContext             job_ctx,
  output logic [NUM_CORES-1:0]  core_ctx_vld,
  input  logic [NUM_CORES-1:0]  core_ctx_rdy,
  output ShaContext             core_ctx,
  output logic                  disp_vld,
  output logic [CORE_W-1:0]     disp_core,
  output logic                  busy
`ifdef SHA256_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_jobs_in,
  output logic [31:0]           stat_jobs_out
`endif
);

  SchedState          state_q, state_d;
  logic [CORE_W-1:0]  sel_q, sel_d;
  logic [CORE_W-1:0]  rr_ptr_q, rr_ptr_d;
  ShaContext          ctx_q, ctx_d;
  logic               disp_vld_q, disp_vld_d;
  logic [CORE_W-1:0]  disp_core_q, disp_core_d;
  logic               busy_q, busy_d;

  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  ShaContext          fifo_head;
  logic [FAW:0]       fifo_cnt_nxt;

  // First ready core at or after ptr, wrapping modulo NUM_CORES. The request
  // vector is rotated so that ptr lands at bit 0, then the lowest set bit wins.
  function automatic logic [CORE_W-1:0] rr_pick(
    input logic [NUM_CORES-1:0] rdy,
    input logic [CORE_W-1:0]    ptr
  );
    logic [2*NUM_CORES-1:0] dbl;
    logic [NUM_CORES-1:0]   rot;
    int                     off;
    int                     idx;
    dbl = {rdy, rdy};
    rot = NUM_CORES'(dbl >> ptr);
    off = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    idx = int'(ptr) + off;
    if (idx >= NUM_CORES) idx = idx - NUM_CORES;
    return CORE_W'(idx);
  endfunction

  assign job_rdy   = !fifo_full;
  assign fifo_push = job_vld && job_rdy;

  sha256_job_fifo #(
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_ctx  (job_ctx),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count_nxt (fifo_cnt_nxt)
  );

  // Select-and-offer sequencing, dispatch reporting and round-robin update.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    ctx_d       = ctx_q;
    fifo_pop    = 1'b0;
    disp_vld_d  = 1'b0;
    disp_core_d = disp_core_q;
    case (state_q)
      SCHED_IDLE: begin
        if (!fifo_empty && (|core_ctx_rdy)) begin
          sel_d   = rr_pick(core_ctx_rdy, rr_ptr_q);
          ctx_d   = fifo_head;
          state_d = SCHED_OFFER;
        end
      end
      SCHED_OFFER: begin
        if (core_ctx_rdy[sel_q]) begin
          fifo_pop    = 1'b1;
          disp_vld_d  = 1'b1;
          disp_core_d = sel_q;
          rr_ptr_d    = (sel_q == CORE_W'(NUM_CORES - 1)) ? '0 : sel_q + CORE_W'(1);
          state_d     = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
    busy_d = (fifo_cnt_nxt != '0) || (state_d == SCHED_OFFER);
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCHED_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      ctx_q       <= '0;
      disp_vld_q  <= 1'b0;
      disp_core_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      ctx_q       <= ctx_d;
      disp_vld_q  <= disp_vld_d;
      disp_core_q <= disp_core_d;
      busy_q      <= busy_d;
    end
  end

  assign core_ctx_vld = (state_q == SCHED_OFFER) ? (NUM_CORES'(1) << sel_q) : '0;
  assign core_ctx     = ctx_q;
  assign disp_vld     = disp_vld_q;
  assign disp_core    = disp_core_q;
  assign busy         = busy_q;

`ifdef SHA256_SCHED_STATS_EN
  logic [31:0] stat_in_q, stat_out_q;

  // Accept and dispatch counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (fifo_push) stat_in_q  <= stat_in_q + 32'd1;
      if (fifo_pop)  stat_out_q <= stat_out_q + 32'd1;
    end
  end

  assign stat_jobs_in  = stat_in_q;
  assign stat_jobs_out = stat_out_q;
`endif

endmodule
